// File: rtl/i2c_slave_resp_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_resp_if
// Bus/handshake bundle for the I2C target.
//   scl_in   : raw SCL from pad (asynchronous to clk)
//   sda_in   : raw SDA from pad (asynchronous to clk)
//   sda_oe   : 1 = pull SDA low (open-drain), 0 = release
//   rx_data  : last byte written by the bus master
//   rx_valid : one-clk pulse when rx_data updates
//   tx_data  : byte to return on the next read
//   tx_req   : one-clk pulse requesting the next read byte
//   busy     : 1 from address match until STOP / repeated START / NACK end
//   rw       : R/W bit of the last matched address byte (1 = read)
// Modport 'slave' is the target side, 'master' is the environment side.
// ---------------------------------------------------------------------------
interface i2c_slave_resp_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       rw;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, rw
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, rw
    );
endinterface

// File: rtl/i2c_slave_resp.sv
// ---------------------------------------------------------------------------
// i2c_slave_resp
// I2C target: oversamples SCL/SDA on clk, detects START/STOP, matches a 7-bit
// address and ACKs it, then either receives write bytes (always ACKed) or
// returns read bytes fetched through a tx_req/tx_data handshake.
// Ports:
//   clk   : system clock, all logic on the rising edge
//   reset : synchronous, active-low
//   bus   : i2c_slave_resp_if.slave (see interface header for signal list)
// All outputs are registered. No clock stretching, no arbitration.
// ---------------------------------------------------------------------------
module i2c_slave_resp #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic            clk,
    input  logic            reset,
    i2c_slave_resp_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_WAIT     = 3'd7
    } state_t;

    // Synchronizer and edge-detect flops
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    // FSM state and registered outputs
    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    // Phase flag: in ACK states it marks "ACK already driven" (ADDR_ACK /
    // WR_ACK) or "master ACKed, waiting for the fall" (RD_ACK).
    logic       r_done;
    logic       r_sda_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;
    logic       r_busy;
    logic       r_rw;

    // Next-state values
    state_t     w_state_nxt;
    logic [7:0] w_shift_nxt;
    logic [2:0] w_cnt_nxt;
    logic       w_done_nxt;
    logic       w_sda_oe_nxt;
    logic [7:0] w_rx_data_nxt;
    logic       w_rx_valid_nxt;
    logic       w_tx_req_nxt;
    logic       w_busy_nxt;
    logic       w_rw_nxt;

    logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop;
    logic [7:0] w_shift_in;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_sda_rise = r_sda_s2 & ~r_sda_d;
    assign w_sda_fall = ~r_sda_s2 & r_sda_d;
    // SDA edges while SCL is high are bus conditions, never data
    assign w_start    = w_sda_fall & r_scl_s2;
    assign w_stop     = w_sda_rise & r_scl_s2;
    assign w_shift_in = {r_shift[6:0], r_sda_s2};

    // Two-flop synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= bus.scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= bus.sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    // FSM state register and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= 8'h00;
            r_cnt      <= 3'd0;
            r_done     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_req   <= w_tx_req_nxt;
            r_busy     <= w_busy_nxt;
            r_rw       <= w_rw_nxt;
        end
    end

    // Next-state and output logic; START/STOP outrank any SCL edge
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_done_nxt     = r_done;
        w_sda_oe_nxt   = r_sda_oe;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_req_nxt   = 1'b0;
        w_busy_nxt     = r_busy;
        w_rw_nxt       = r_rw;

        if (w_start) begin
            w_state_nxt  = ST_ADDR;
            w_cnt_nxt    = 3'd0;
            w_done_nxt   = 1'b0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = 3'd0;
            w_done_nxt   = 1'b0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_sda_oe_nxt = 1'b0;
                end

                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_shift_in;
                        if (r_cnt == 3'd7) begin
                            w_cnt_nxt  = 3'd0;
                            w_done_nxt = 1'b0;
                            if (w_shift_in[7:1] == SLAVE_ADDR) begin
                                w_rw_nxt     = w_shift_in[0];
                                w_busy_nxt   = 1'b1;
                                // Ask for the first read byte early: it is
                                // only loaded at the end of the ACK slot
                                w_tx_req_nxt = w_shift_in[0];
                                w_state_nxt  = ST_ADDR_ACK;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 3'd1;
                        end
                    end else begin
                        w_shift_nxt = r_shift;
                    end
                end

                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_done) begin
                            w_sda_oe_nxt = 1'b1;
                            w_done_nxt   = 1'b1;
                        end else begin
                            w_cnt_nxt  = 3'd0;
                            w_done_nxt = 1'b0;
                            if ((r_state == ST_ADDR_ACK) && r_rw) begin
                                w_shift_nxt  = bus.tx_data;
                                w_sda_oe_nxt = ~bus.tx_data[7];
                                w_state_nxt  = ST_RD_DATA;
                            end else begin
                                w_sda_oe_nxt = 1'b0;
                                w_state_nxt  = ST_WR_DATA;
                            end
                        end
                    end else begin
                        w_done_nxt = r_done;
                    end
                end

                ST_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_shift_in;
                        if (r_cnt == 3'd7) begin
                            w_rx_data_nxt  = w_shift_in;
                            w_rx_valid_nxt = 1'b1;
                            w_cnt_nxt      = 3'd0;
                            w_done_nxt     = 1'b0;
                            w_state_nxt    = ST_WR_ACK;
                        end else begin
                            w_cnt_nxt = r_cnt + 3'd1;
                        end
                    end else begin
                        w_shift_nxt = r_shift;
                    end
                end

                ST_RD_DATA: begin
                    // Bit 7 is already on the bus at entry; each fall
                    // presents the next bit, the 8th fall frees SDA.
                    if (w_scl_fall) begin
                        if (r_cnt == 3'd7) begin
                            w_sda_oe_nxt = 1'b0;
                            w_cnt_nxt    = 3'd0;
                            w_done_nxt   = 1'b0;
                            w_state_nxt  = ST_RD_ACK;
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                            w_cnt_nxt    = r_cnt + 3'd1;
                        end
                    end else begin
                        w_shift_nxt = r_shift;
                    end
                end

                ST_RD_ACK: begin
                    if (w_scl_rise && !r_done) begin
                        if (!r_sda_s2) begin
                            w_tx_req_nxt = 1'b1;
                            w_done_nxt   = 1'b1;
                        end else begin
                            w_busy_nxt  = 1'b0;
                            w_cnt_nxt   = 3'd0;
                            w_done_nxt  = 1'b0;
                            w_state_nxt = ST_WAIT;
                        end
                    end else if (w_scl_fall && r_done) begin
                        w_shift_nxt  = bus.tx_data;
                        w_sda_oe_nxt = ~bus.tx_data[7];
                        w_cnt_nxt    = 3'd0;
                        w_done_nxt   = 1'b0;
                        w_state_nxt  = ST_RD_DATA;
                    end else begin
                        w_done_nxt = r_done;
                    end
                end

                ST_WAIT: begin
                    w_sda_oe_nxt = 1'b0;
                end

                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_sda_oe_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.tx_req   = r_tx_req;
    assign bus.busy     = r_busy;
    assign bus.rw       = r_rw;

endmodule

// File: doc/i2c_slave_resp.md
Name: i2c_slave_resp

Overview:
- I2C target (responder): the far end of the bus driven by the team's I2C master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs it.
- Presents written bytes on a byte-wide output and sources read bytes from a byte-wide input via a request strobe.
- Used as a bus-functional peer in system benches and as a synthesizable on-chip target.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address this block responds to.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-low; sampled on clk rising edge.
- scl_in  input  1  raw SCL from pad, asynchronous.
- sda_in  input  1  raw SDA from pad, asynchronous.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- rx_data  output  8  last byte written by master.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_data  input  8  byte to return on next read; must be stable from tx_req until next SCL fall.
- tx_req  output  1  one-clk pulse requesting next read byte.
- busy  output  1  1 from address match until STOP / repeated START / NACK end.
- rw  output  1  R/W bit of last matched address byte (1 = read).

Behaviour:
- Reset (reset=0 at clk edge): state IDLE, sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, rw=0, bit counter=0, sync flops=1.
- Input conditioning: 2-flop synchronizer per line plus a 1-clk delayed copy. scl_rise/scl_fall/sda_rise/sda_fall are 1-clk pulses from synced vs delayed. Each SCL high/low phase ≥ 4 clk.
- Bus events:
  - START = sda_fall while synced SCL=1.
  - STOP = sda_rise while synced SCL=1.
  - Data sampled only on scl_rise; sda_oe changes only on the clk after scl_fall.
- START (incl. repeated) from any state: go ADDR, bit counter=0, sda_oe=0, busy=0.
- STOP from any state: go IDLE, sda_oe=0, busy=0.
- START/STOP outrank any scl edge in the same clk.
- States:
  - IDLE: ignore SCL; wait for START.
  - ADDR: shift sda into 8-bit shift register on each scl_rise, MSB first. After the 8th rise:
    - if shift[7:1]==SLAVE_ADDR: latch rw=shift[0], busy=1, go ADDR_ACK. If rw=1, pulse tx_req on this same clk.
    - else go IDLE (no ACK, sda_oe stays 0).
  - ADDR_ACK: on first scl_fall set sda_oe=1. On the next scl_fall:
    - if rw=0: sda_oe=0, go WR_DATA.
    - if rw=1: load shift<=tx_data, sda_oe=~tx_data[7], go RD_DATA.
  - WR_DATA: shift 8 bits on scl_rise. On the 8th rise: rx_data<=shifted byte, rx_valid pulse, go WR_ACK.
  - WR_ACK: identical ACK drive to ADDR_ACK, then back to WR_DATA with counter=0. The slave always ACKs writes.
  - RD_DATA: on each scl_fall after the first bit, shift left and drive sda_oe=~shift[7]. After the 8th bit's scl_fall, sda_oe=0 and go RD_ACK.
  - RD_ACK: sample sda on scl_rise.
    - 0 (ACK): pulse tx_req that clk. On next scl_fall load tx_data and drive bit 7, go RD_DATA.
    - 1 (NACK): go WAIT, busy=0.
  - WAIT: sda_oe=0; only START/STOP leave.
- Bit counter: 3 bits plus done flag, cleared on every state entry.
- Clock stretching: none.
- Arbitration: none; SDA read-back is not compared.
- Reset mid-transfer: immediate release of SDA on the next clk. The master sees NACK or data 0xFF.

Test Plan:
- Write: START, 0xA0 (0x50+W), 0xA5, 0x3C, STOP -> ACK low for 3 ACK slots; rx_valid pulses twice with rx_data 0xA5 then 0x3C; busy 1→0 at STOP; rw=0.
- Mismatch: START, 0xA2, 0x11, STOP -> sda_oe never asserted; no rx_valid; busy stays 0.
- Read: START, 0xA1, tx_data=0x96 on first tx_req, master ACK, tx_data=0x5A, master NACK, STOP -> bus bits 10010110 then 01011010; exactly 2 tx_req pulses; busy drops at NACK.
- Repeated start: START, 0xA0, 0x01, Sr, 0xA1, read 1 byte with NACK, STOP -> rx_data=0x01; rw switches 0→1; sda_oe=0 on the clk after Sr.
- Reset mid-byte: assert reset=0 for 1 clk after 4 data bits of a read of 0x00 -> sda_oe=0 on next clk; all outputs at reset values; next START+0xA0 is ACKed normally.
- Edge timing: SCL phases of exactly 4 clk -> same results as above; sda_oe never changes while synced SCL=1.
